pifo_dequeue_agent: RTL and testbench
=====================================

Name: pifo_dequeue_agent

Overview:
- Dequeue-side counterpart of the enqueue agent in the PIFO scheduler.
- Watches the per-port data and metadata buffers that the enqueue agent fills, and pops the eligible head packet with the lowest rank (push-in, first-out semantics).
- Streams the chosen packet out on a NetFPGA-SUME AXI4-Stream master toward the output arbiter.

Parameters:
- DATA_WIDTH, 256, AXIS data width in bits.
- SUME_META_WIDTH, 128, tuser/metadata width in bits.
- PORT_NUM, 5, number of per-port queue pairs.
- RANK_WIDTH, 16, width of the rank field.
- RANK_LSB, 32, LSB position of the rank field within the metadata word.

Ports:
- clk_in_0  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- data_dout  in  PORT_NUM*DATA_WIDTH  FWFT head data per port; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- data_keep  in  PORT_NUM*DATA_WIDTH/8  FWFT head tkeep per port.
- data_last  in  PORT_NUM  FWFT head tlast per port.
- data_empty  in  PORT_NUM  data buffer empty per port.
- data_rd_en  out  PORT_NUM  data buffer pop strobe.
- meta_dout  in  PORT_NUM*SUME_META_WIDTH  FWFT head metadata per port.
- meta_empty  in  PORT_NUM  metadata buffer empty per port.
- meta_rd_en  out  PORT_NUM  metadata buffer pop strobe.
- m_axis_tdata  out  DATA_WIDTH  output stream data.
- m_axis_tkeep  out  DATA_WIDTH/8  output byte enables.
- m_axis_tuser  out  SUME_META_WIDTH  metadata; valid on the first beat only.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  end of packet.
- m_axis_tready  in  1  downstream ready.
- pkt_count  out  32  count of packets fully dequeued; wraps modulo 2^32.

Behaviour:
Buffers:
- All buffers are first-word-fall-through: head word is visible while empty is low; rd_en pops the head.

Reset:
- Any reset assertion, including mid-packet, forces state to IDLE.
- Clears sel_port, first_beat and pkt_count.
- All outputs drive 0 while in reset; buffer contents are left untouched.

Eligibility and rank:
- Port i is eligible when !meta_empty[i] && !data_empty[i].
- rank_i = meta_dout[i*SUME_META_WIDTH + RANK_LSB +: RANK_WIDTH], compared unsigned; smaller rank wins.
- Ties go to the lowest port index.

FSM with two states, IDLE and SEND:
- IDLE: if any port is eligible, register the winner into sel_port, set first_beat=1 and go to SEND. Otherwise stay in IDLE.
  - Arbitration costs exactly one cycle, so there is one idle bubble between packets.
- SEND, output datapath (combinational mux from port sel_port):
  - m_axis_tvalid = !data_empty[sel_port].
  - m_axis_tdata, m_axis_tkeep and m_axis_tlast come from that port's data head.
  - m_axis_tuser = meta_dout[sel_port] when first_beat, else 0.
- SEND, on a beat handshake (tvalid && tready):
  - data_rd_en[sel_port] = 1.
  - If first_beat: meta_rd_en[sel_port] = 1 and first_beat clears.
  - If tlast: pkt_count increments and the FSM returns to IDLE.
  - A single-beat packet pops meta and data and returns to IDLE in the same cycle.
- SEND, data buffer empty mid-packet: tvalid drops and the FSM holds in SEND (no timeout, no preemption).
- Selection is locked for the whole packet; lower-rank arrivals wait for the next IDLE.

Other rules:
- All rd_en bits are 0 outside a handshake cycle and never pop a non-selected port.
- Outputs hold stable while tvalid=1 and tready=0.

Decomposition:
- Shared package pifo_pkg holds:
  - state encoding (ST_IDLE, ST_SEND);
  - the rank-extract helper (RANK_LSB/RANK_WIDTH);
  - SUME tuser field offsets.
- One sub-module, pifo_min_rank_select: combinational PORT_NUM-way min-rank finder with eligibility mask and lowest-index tie-break.
  - Outputs: winner index and any_valid.
  - Reused later by the drop/push-out logic.

Test Plan:
1. Single packet, port 2, rank 7, 3 beats, tready=1: sel at cycle 1, beats at cycles 2-4, tuser only on beat 1, meta_rd_en[2] one pulse, pkt_count=1.
2. Ports 0, 1 and 3 eligible with ranks 9, 4, 4: port 1 is sent first, then port 3, then port 0; each packet is preceded by one IDLE bubble.
3. Backpressure: tready toggles 1-0-0-1 during a 4-beat packet: data and user held stable while stalled, exactly 4 data_rd_en pulses, no duplicate beats.
4. Data buffer underrun: data_empty goes high after beat 1 for 5 cycles: tvalid=0, FSM stays in SEND, packet resumes with beat 2; meta is not popped a second time.
5. One-beat packets back-to-back on port 4, tlast on beat 1: meta and data popped in the same cycle, pkt_count steps 1, 2, 3 at a 2-cycle cadence.
6. Reset asserted asynchronously mid-packet on beat 2: outputs go to 0 immediately, pkt_count=0, IDLE after release; the remaining beats are re-arbitrated as the head of port traffic.

Source files
------------

// File: rtl/pifo_pkg.sv
// Shared types and helpers for the PIFO scheduler agents: FSM state encoding,
// SUME metadata field offsets and the rank-extract helper.
package pifo_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  localparam int SUME_META_W   = 128;
  localparam int RANK_W        = 16;
  // The rank lives in the spare field of the SUME tuser word.
  localparam int SUME_RANK_LSB = 32;

  function automatic logic [RANK_W-1:0] rank_of(input logic [SUME_META_W-1:0] meta,
                                                input int lsb);
    return meta[lsb +: RANK_W];
  endfunction

endpackage

// File: rtl/pifo_dequeue_agent_if.sv
// Buffer-side and AXI4-Stream-side signals of the dequeue agent; the master
// modport is the agent's view, the slave modport the environment's view.
interface pifo_dequeue_agent_if #(
  parameter int DATA_WIDTH      = 256,
  parameter int SUME_META_WIDTH = 128,
  parameter int PORT_NUM        = 5
);
  logic [PORT_NUM*DATA_WIDTH-1:0]      data_dout;
  logic [PORT_NUM*DATA_WIDTH/8-1:0]    data_keep;
  logic [PORT_NUM-1:0]                 data_last;
  logic [PORT_NUM-1:0]                 data_empty;
  logic [PORT_NUM-1:0]                 data_rd_en;
  logic [PORT_NUM*SUME_META_WIDTH-1:0] meta_dout;
  logic [PORT_NUM-1:0]                 meta_empty;
  logic [PORT_NUM-1:0]                 meta_rd_en;
  logic [DATA_WIDTH-1:0]               m_axis_tdata;
  logic [DATA_WIDTH/8-1:0]             m_axis_tkeep;
  logic [SUME_META_WIDTH-1:0]          m_axis_tuser;
  logic                                m_axis_tvalid;
  logic                                m_axis_tlast;
  logic                                m_axis_tready;

  modport master (
    input  data_dout, data_keep, data_last, data_empty, meta_dout, meta_empty, m_axis_tready,
    output data_rd_en, meta_rd_en,
    output m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output data_dout, data_keep, data_last, data_empty, meta_dout, meta_empty, m_axis_tready,
    input  data_rd_en, meta_rd_en,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/pifo_min_rank_select.sv
// Combinational N-way minimum-rank finder over an eligibility mask; equal
// ranks resolve to the lowest index.
module pifo_min_rank_select #(
  parameter int N = 5,
  parameter int W = 16,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0][W-1:0] rank_i,
  input  logic [N-1:0]        elig_i,
  output logic [IW-1:0]       winner_o,
  output logic                any_valid_o
);

  logic [W-1:0] best;

  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    best        = '0;
    for (int i = 0; i < N; i++) begin
      if (elig_i[i] && (!any_valid_o || rank_i[i] < best)) begin
        winner_o    = IW'(i);
        best        = rank_i[i];
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pifo_dequeue_agent.sv
// PIFO dequeue agent: picks the eligible port head with the lowest rank and
// streams that packet out on an AXI4-Stream master, one packet at a time.
module pifo_dequeue_agent
  import pifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 256,
  parameter int SUME_META_WIDTH = 128,
  parameter int PORT_NUM        = 5,
  parameter int RANK_WIDTH      = RANK_W,
  parameter int RANK_LSB        = SUME_RANK_LSB
) (
  input  logic                  clk_in_0,
  input  logic                  reset,
  pifo_dequeue_agent_if.master  bus,
  output logic [31:0]           pkt_count
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

  state_e          state_q, state_d;
  logic [IW-1:0]   sel_port_q, sel_port_d;
  logic            first_beat_q, first_beat_d;
  logic [31:0]     pkt_count_q, pkt_count_d;

  logic [PORT_NUM-1:0][DATA_WIDTH-1:0]      pdata;
  logic [PORT_NUM-1:0][KW-1:0]              pkeep;
  logic [PORT_NUM-1:0][SUME_META_WIDTH-1:0] pmeta;
  logic [PORT_NUM-1:0][RANK_WIDTH-1:0]      rank;
  logic [PORT_NUM-1:0]                      elig;
  logic [IW-1:0]                            winner;
  logic                                     any_valid;
  logic                                     beat_vld;

  assign pdata = bus.data_dout;
  assign pkeep = bus.data_keep;
  assign pmeta = bus.meta_dout;
  assign elig  = ~bus.meta_empty & ~bus.data_empty;

  for (genvar i = 0; i < PORT_NUM; i++) begin : g_rank
    assign rank[i] = RANK_WIDTH'(rank_of(SUME_META_W'(pmeta[i]), RANK_LSB));
  end

  pifo_min_rank_select #(
    .N (PORT_NUM),
    .W (RANK_WIDTH)
  ) u_sel (
    .rank_i      (rank),
    .elig_i      (elig),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  assign beat_vld = (state_q == ST_SEND) && !bus.data_empty[sel_port_q];

  always_comb begin
    state_d           = state_q;
    sel_port_d        = sel_port_q;
    first_beat_d      = first_beat_q;
    pkt_count_d       = pkt_count_q;
    bus.m_axis_tvalid = 1'b0;
    bus.m_axis_tdata  = '0;
    bus.m_axis_tkeep  = '0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tuser  = '0;
    bus.data_rd_en    = '0;
    bus.meta_rd_en    = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          sel_port_d   = winner;
          first_beat_d = 1'b1;
          state_d      = ST_SEND;
        end
      end
      ST_SEND: begin
        // Selection stays locked until tlast; an underrun just stalls the stream.
        bus.m_axis_tvalid = beat_vld;
        bus.m_axis_tdata  = pdata[sel_port_q];
        bus.m_axis_tkeep  = pkeep[sel_port_q];
        bus.m_axis_tlast  = bus.data_last[sel_port_q];
        bus.m_axis_tuser  = first_beat_q ? pmeta[sel_port_q] : '0;
        if (beat_vld && bus.m_axis_tready) begin
          bus.data_rd_en[sel_port_q] = 1'b1;
          if (first_beat_q) begin
            bus.meta_rd_en[sel_port_q] = 1'b1;
            first_beat_d               = 1'b0;
          end
          if (bus.data_last[sel_port_q]) begin
            pkt_count_d = pkt_count_q + 32'd1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in_0 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sel_port_q   <= '0;
      first_beat_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_port_q   <= sel_port_d;
      first_beat_q <= first_beat_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_pifo_dequeue_agent.sv
// Bench for pifo_dequeue_agent: FWFT buffer models per port, a packet-level
// reference that orders packets by (rank, port), and a beat scoreboard.
module tb_pifo_dequeue_agent;
  localparam int DW = 256;
  localparam int MW = 128;
  localparam int P  = 5;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [MW-1:0] user;
    int            port;
    bit            first;
  } exp_t;

  typedef struct {
    int            port;
    logic [15:0]   rank;
    int            nb;
    logic [31:0]   seed;
    logic [MW-1:0] meta;
  } pkt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pkt_count;

  pifo_dequeue_agent_if #(.DATA_WIDTH(DW), .SUME_META_WIDTH(MW), .PORT_NUM(P)) bus ();

  pifo_dequeue_agent #(
    .DATA_WIDTH(DW), .SUME_META_WIDTH(MW), .PORT_NUM(P), .RANK_WIDTH(16), .RANK_LSB(32)
  ) dut (
    .clk_in_0  (clk),
    .reset     (rst),
    .bus       (bus),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  beat_t         dq[P][$];
  logic [MW-1:0] mq[P][$];
  pkt_t          pq[P][$];
  exp_t          expq[$];
  int            hs_cyc[$];
  int            first_ports[$];
  bit            hold[P];

  int          checks = 0, failures = 0;
  int          cyc = 0, last_cyc = 0, drd_cnt = 0, mrd_cnt = 0;
  bit          bubble_chk = 0, saw_last = 0, prev_stall = 0;
  logic [31:0] exp_cnt = '0;

  logic          s_v, s_l, s_rdy;
  logic [DW-1:0] s_d, p_d;
  logic [KW-1:0] s_k;
  logic [MW-1:0] s_u, p_u;
  logic [P-1:0]  s_drd, s_mrd;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [P-1:0] onehot(input int port);
    logic [P-1:0] r = '0;
    r[port] = 1'b1;
    return r;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] seed, input int b, input int nb);
    beat_t x;
    x.data = {8{seed ^ (32'(b) * 32'h9E37_79B9)}};
    x.last = (b == nb - 1);
    x.keep = x.last ? ({KW{1'b1}} >> seed[4:0]) : {KW{1'b1}};
    return x;
  endfunction

  function automatic logic [MW-1:0] mk_meta(input logic [15:0] rank, input logic [31:0] seed);
    logic [MW-1:0] m = {seed, ~seed, seed, ~seed};
    m[32 +: 16] = rank;
    return m;
  endfunction

  task automatic push_pkt(input int port, input logic [15:0] rank, input int nb, output pkt_t k);
    k.port = port; k.rank = rank; k.nb = nb; k.seed = $urandom;
    k.meta = mk_meta(rank, k.seed);
    for (int b = 0; b < nb; b++) dq[port].push_back(mk_beat(k.seed, b, nb));
    mq[port].push_back(k.meta);
    pq[port].push_back(k);
  endtask

  // Reference: repeatedly emit the head packet with the smallest rank, lowest port on ties.
  task automatic model_order();
    pkt_t k;
    exp_t e;
    beat_t x;
    forever begin
      int best = -1;
      for (int p = 0; p < P; p++)
        if (pq[p].size() > 0 && (best < 0 || pq[p][0].rank < pq[best][0].rank)) best = p;
      if (best < 0) break;
      k = pq[best].pop_front();
      for (int b = 0; b < k.nb; b++) begin
        x = mk_beat(k.seed, b, k.nb);
        e.data = x.data; e.keep = x.keep; e.last = x.last;
        e.user = (b == 0) ? k.meta : '0;
        e.port = best; e.first = (b == 0);
        expq.push_back(e);
      end
    end
  endtask

  task automatic refresh();
    for (int p = 0; p < P; p++) begin
      bus.data_empty[p] = (dq[p].size() == 0) || hold[p];
      if (dq[p].size() > 0) begin
        bus.data_dout[p*DW +: DW] = dq[p][0].data;
        bus.data_keep[p*KW +: KW] = dq[p][0].keep;
        bus.data_last[p]          = dq[p][0].last;
      end else begin
        bus.data_dout[p*DW +: DW] = '0;
        bus.data_keep[p*KW +: KW] = '0;
        bus.data_last[p]          = 1'b0;
      end
      bus.meta_empty[p] = (mq[p].size() == 0);
      bus.meta_dout[p*MW +: MW] = (mq[p].size() > 0) ? mq[p][0] : '0;
    end
  endtask

  task automatic snapshot();
    s_v = bus.m_axis_tvalid; s_d = bus.m_axis_tdata; s_k = bus.m_axis_tkeep;
    s_l = bus.m_axis_tlast;  s_u = bus.m_axis_tuser; s_rdy = bus.m_axis_tready;
    s_drd = bus.data_rd_en;  s_mrd = bus.meta_rd_en;
  endtask

  task automatic settle();
    refresh();
    #1;
    snapshot();
  endtask

  // Retire the cycle that just ended at the posedge, using the outputs sampled before it.
  task automatic commit();
    exp_t e;
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", DW'(s_v), DW'(1));
      chk("stall_data", s_d, p_d);
      chk("stall_user", DW'(s_u), DW'(p_u));
    end
    prev_stall = s_v && !s_rdy;
    p_d = s_d; p_u = s_u;
    drd_cnt += $countones(s_drd);
    mrd_cnt += $countones(s_mrd);
    if (s_v && s_rdy) begin
      hs_cyc.push_back(cyc);
      if (expq.size() == 0) chk("extra_beat", DW'(1), DW'(0));
      else begin
        e = expq.pop_front();
        chk("tdata", s_d, e.data);
        chk("tkeep", DW'(s_k), DW'(e.keep));
        chk("tlast", DW'(s_l), DW'(e.last));
        chk("tuser", DW'(s_u), DW'(e.user));
        chk("data_rd_en", DW'(s_drd), DW'(onehot(e.port)));
        chk("meta_rd_en", DW'(s_mrd), e.first ? DW'(onehot(e.port)) : '0);
        if (e.first) begin
          first_ports.push_back(e.port);
          if (bubble_chk && saw_last) chk("bubble", DW'(cyc - last_cyc), DW'(2));
        end
        if (e.last) begin exp_cnt++; last_cyc = cyc; saw_last = 1; end
      end
    end else chk("rd_en_idle", DW'({s_drd, s_mrd}), '0);
    for (int p = 0; p < P; p++) begin
      if (s_drd[p] && dq[p].size() > 0) void'(dq[p].pop_front());
      if (s_mrd[p] && mq[p].size() > 0) void'(mq[p].pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    commit();
    refresh();
    @(negedge clk);
    snapshot();
    chk("pkt_count", DW'(pkt_count), DW'(exp_cnt));
  endtask

  task automatic run_until_empty(input int budget, input bit rnd);
    int n = 0;
    while (expq.size() > 0 && n < budget) begin
      bus.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      settle();
      tick();
      n++;
    end
    chk("drain_timeout", DW'(expq.size()), '0);
  endtask

  task automatic new_test(input bit bub);
    hs_cyc.delete(); first_ports.delete();
    drd_cnt = 0; mrd_cnt = 0; saw_last = 0; bubble_chk = bub;
  endtask

  initial begin
    pkt_t k, ka;
    int c0;
    bit pat[7] = '{1, 0, 0, 1, 1, 1, 1};
    beat_t x;
    exp_t e;
    logic [MW-1:0] m2;

    // Reset state
    rst = 1'b1;
    bus.m_axis_tready = 1'b0;
    for (int p = 0; p < P; p++) hold[p] = 0;
    refresh();
    #1;
    chk("rst_tvalid", DW'(bus.m_axis_tvalid), '0);
    chk("rst_rd_en", DW'({bus.data_rd_en, bus.meta_rd_en}), '0);
    chk("rst_pkt_count", DW'(pkt_count), '0);
    @(negedge clk);
    rst = 1'b0;
    settle();

    // 1: single 3-beat packet on port 2, rank 7
    new_test(0);
    push_pkt(2, 16'd7, 3, k);
    model_order();
    c0 = cyc;
    run_until_empty(50, 0);
    chk("t1_beats", DW'(hs_cyc.size()), DW'(3));
    if (hs_cyc.size() == 3) begin
      chk("t1_cyc0", DW'(hs_cyc[0] - c0), DW'(2));
      chk("t1_cyc2", DW'(hs_cyc[2] - c0), DW'(4));
    end
    chk("t1_meta_pops", DW'(mrd_cnt), DW'(1));
    chk("t1_count", DW'(pkt_count), DW'(1));

    // 2: ranks 9,4,4 on ports 0,1,3 -> order 1,3,0 with one bubble between packets
    new_test(1);
    push_pkt(0, 16'd9, $urandom_range(1, 3), k);
    push_pkt(1, 16'd4, $urandom_range(1, 3), k);
    push_pkt(3, 16'd4, $urandom_range(1, 3), k);
    model_order();
    run_until_empty(80, 0);
    chk("t2_npkts", DW'(first_ports.size()), DW'(3));
    if (first_ports.size() == 3) begin
      chk("t2_first", DW'(first_ports[0]), DW'(1));
      chk("t2_second", DW'(first_ports[1]), DW'(3));
      chk("t2_third", DW'(first_ports[2]), DW'(0));
    end

    // 3: backpressure 1-0-0-1 on a 4-beat packet
    new_test(0);
    push_pkt(3, 16'd2, 4, k);
    model_order();
    bus.m_axis_tready = 1'b1;
    settle();
    tick();
    for (int i = 0; i < 7; i++) begin
      bus.m_axis_tready = pat[i];
      settle();
      tick();
    end
    chk("t3_drain", DW'(expq.size()), '0);
    chk("t3_rd_pulses", DW'(drd_cnt), DW'(4));

    // 4: underrun after beat 1 for 5 cycles; a lower-rank arrival must wait
    new_test(0);
    push_pkt(2, 16'd10, 3, k);
    model_order();
    bus.m_axis_tready = 1'b1;
    settle();
    tick();
    tick();
    chk("t4_beat1", DW'(hs_cyc.size()), DW'(1));
    hold[2] = 1;
    push_pkt(0, 16'd1, 2, k);
    model_order();
    settle();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_underrun_tvalid", DW'(s_v), '0);
    end
    hold[2] = 0;
    run_until_empty(50, 0);
    chk("t4_meta_pops", DW'(mrd_cnt), DW'(2));
    chk("t4_order", DW'(first_ports.size() == 2 ? first_ports[1] : -1), DW'(0));

    // 5: back-to-back single-beat packets on port 4
    new_test(1);
    for (int i = 0; i < 3; i++) push_pkt(4, 16'($urandom_range(0, 15)), 1, k);
    model_order();
    c0 = cyc;
    run_until_empty(50, 0);
    chk("t5_beats", DW'(hs_cyc.size()), DW'(3));
    if (hs_cyc.size() == 3)
      for (int i = 0; i < 3; i++) chk("t5_cadence", DW'(hs_cyc[i] - c0), DW'(2 + 2 * i));

    // 6: asynchronous reset while beat 2 of a 4-beat packet is presented
    new_test(0);
    push_pkt(2, 16'd3, 4, ka);
    model_order();
    bus.m_axis_tready = 1'b1;
    settle();
    tick();
    tick();
    chk("t6_pre_valid", DW'(s_v), DW'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_tvalid", DW'(bus.m_axis_tvalid), '0);
    chk("t6_rst_tdata", bus.m_axis_tdata, '0);
    chk("t6_rst_tuser", DW'(bus.m_axis_tuser), '0);
    chk("t6_rst_rd_en", DW'({bus.data_rd_en, bus.meta_rd_en}), '0);
    chk("t6_rst_count", DW'(pkt_count), '0);
    expq.delete();
    exp_cnt = '0;
    prev_stall = 0;
    snapshot();
    tick();
    @(negedge clk);
    #2;
    rst = 1'b0;
    settle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_idle_no_meta", DW'(s_v), '0);
    end
    m2 = mk_meta(16'd5, ~ka.seed);
    mq[2].push_back(m2);
    for (int b = 1; b < 4; b++) begin
      x = mk_beat(ka.seed, b, 4);
      e.data = x.data; e.keep = x.keep; e.last = x.last;
      e.user = (b == 1) ? m2 : '0; e.port = 2; e.first = (b == 1);
      expq.push_back(e);
    end
    settle();
    run_until_empty(50, 0);
    chk("t6_port2_empty", DW'(dq[2].size() + mq[2].size()), '0);

    // Randomized rounds: random ports, ranks with frequent ties, random tready
    for (int r = 0; r < 8; r++) begin
      new_test(0);
      for (int i = 0, n = $urandom_range(1, 5); i < n; i++)
        push_pkt($urandom_range(0, P - 1), 16'($urandom_range(0, 7)), $urandom_range(1, 4), k);
      model_order();
      run_until_empty(400, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
